// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one req/ack fetch at a time,
// holds the fetched word for decode and applies PC-relative branches and halt.
module fetch_sequencer #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  OFFSET_WIDTH = 25,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [PC_WIDTH-1:0]     instr_pc,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    halt,
    output logic                    halted,
    output logic [PC_WIDTH-1:0]     retired
);

    typedef enum logic [1:0] {
        S_START,
        S_FETCH,
        S_VALID,
        S_HALT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] branch_target;

    assign offset_ext    = {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};
    assign branch_target = instr_pc + PC_WIDTH'(1) + offset_ext;
    assign imem_addr     = pc;

    // NOTE: all state updates are non-blocking so every register sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_START;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                // One idle cycle after reset discards any ack left over from an aborted fetch.
                S_START: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + PC_WIDTH'(1);
                        imem_req    <= 1'b0;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        retired     <= retired + PC_WIDTH'(1);
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                            if (branch_taken) begin
                                pc <= branch_target;
                            end
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed decode stimulus, a latency-configurable
// memory responder, and a negedge monitor that pops expected fetches and consumes.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        branch_taken;
    logic [24:0] branch_offset;
    logic        halt;
    logic        halted;
    logic [31:0] retired;

    fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .halt         (halt),
        .halted       (halted),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } cons_t;

    logic [31:0] addr_q[$];
    cons_t       cons_q[$];

    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          stale_ack = 0;
    logic [31:0] exp_retired = 0;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return 32'h5A5A_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        cons_t c;
        c.pc   = a;
        c.word = mw(a);
        addr_q.push_back(a);
        cons_q.push_back(c);
    endtask

    // Memory responder: acks after ack_delay waiting cycles, garbage data while waiting.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (stale_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hBAD0_BAD0;
                wait_cnt   = 0;
            end else if (imem_req) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mw(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'hBAD0_0000 + 32'(wait_cnt);
                    wait_cnt++;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = '0;
                wait_cnt   = 0;
            end
        end
    end

    // Monitor: compares every completed fetch and every consume against the queues.
    logic [31:0] mon_addr;
    cons_t       mon_cons;
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (imem_req && imem_ack) begin
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_unexpected: got addr %0h expected no fetch", imem_addr);
                    end else begin
                        mon_addr = addr_q.pop_front();
                        check("fetch_addr", 64'(imem_addr), 64'(mon_addr));
                    end
                end
                if (instr_valid && !stall) begin
                    if (cons_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL consume_unexpected: got instr_pc %0h expected no consume", instr_pc);
                    end else begin
                        mon_cons = cons_q.pop_front();
                        check("consume_pc", 64'(instr_pc), 64'(mon_cons.pc));
                        check("consume_instr", 64'(instr), 64'(mon_cons.word));
                    end
                end
            end
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got no instr_valid expected instr_valid within 50 cycles");
        end
    endtask

    // Consume the presented instruction with the given decode inputs.
    task automatic step(input logic br, input logic [24:0] off, input logic hl, input int dly);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            stall         = 1'b0;
            branch_taken  = br;
            branch_offset = off;
            halt          = hl;
            ack_delay     = dly;
            @(posedge clk);
            #1;
            branch_taken = 1'b0;
            halt         = 1'b0;
            exp_retired  = exp_retired + 1;
            check("retired_step", 64'(retired), 64'(exp_retired));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int req_seen;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = '0;
        halt          = 1'b0;

        @(posedge clk);
        #1;
        check("rst_req", 64'(imem_req), 64'(0));
        check("rst_valid", 64'(instr_valid), 64'(0));
        check("rst_instr", 64'(instr), 64'(0));
        check("rst_instr_pc", 64'(instr_pc), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_retired", 64'(retired), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("start_no_req", 64'(imem_req), 64'(0));
        expect_fetch(32'h0);
        @(posedge clk);
        #1;
        check("first_req", 64'(imem_req), 64'(1));
        check("first_addr", 64'(imem_addr), 64'(0));

        // Sequential run 0..3, then straight into 4.
        for (int a = 1; a <= 4; a++) begin
            expect_fetch(32'(a));
            step(1'b0, '0, 1'b0, 0);
        end
        check("retired_4", 64'(retired), 64'(4));

        // Branches: 4 -> 0x10, 0x10 back to 0x0D, 0x0D -> 0x10, 0x10 forward to 0x16.
        expect_fetch(32'h10);
        step(1'b1, 25'd11, 1'b0, 0);
        expect_fetch(32'h0D);
        step(1'b1, 25'h1FF_FFFC, 1'b0, 0);
        expect_fetch(32'h10);
        step(1'b1, 25'd2, 1'b0, 0);
        expect_fetch(32'h16);
        step(1'b1, 25'd5, 1'b0, 0);

        // Stall with a branch request present: must hold and must not redirect.
        wait_valid(ok);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 25'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 64'(instr_valid), 64'(1));
            check("stall_instr", 64'(instr), 64'(mw(32'h16)));
            check("stall_instr_pc", 64'(instr_pc), 64'(32'h16));
            check("stall_retired", 64'(retired), 64'(exp_retired));
        end
        expect_fetch(32'h17);
        stall        = 1'b0;
        branch_taken = 1'b0;
        ack_delay    = 5;
        @(posedge clk);
        #1;
        exp_retired = exp_retired + 1;
        check("stall_release_retired", 64'(retired), 64'(exp_retired));

        // Memory wait: request and address stay put through five ack-less cycles.
        for (int i = 0; i < 5; i++) begin
            check("wait_req", 64'(imem_req), 64'(1));
            check("wait_addr", 64'(imem_addr), 64'(32'h17));
            check("wait_valid", 64'(instr_valid), 64'(0));
            @(posedge clk);
            #1;
        end
        ack_delay = 0;
        expect_fetch(32'h18);
        step(1'b0, '0, 1'b0, 0);

        // Halt wins over a simultaneous branch.
        step(1'b1, 25'd5, 1'b1, 0);
        check("halt_halted", 64'(halted), 64'(1));
        check("halt_valid", 64'(instr_valid), 64'(0));
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (imem_req) req_seen++;
        end
        check("halt_no_req", 64'(req_seen), 64'(0));
        check("halt_stays", 64'(halted), 64'(1));

        // Reset out of halt.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_halted", 64'(halted), 64'(0));
        check("rst2_pc", 64'(imem_addr), 64'(0));
        check("rst2_retired", 64'(retired), 64'(0));
        exp_retired = 0;
        rst = 1'b0;
        check("rst2_start_no_req", 64'(imem_req), 64'(0));
        expect_fetch(32'h0);
        @(posedge clk);
        #1;
        check("rst2_first_req", 64'(imem_req), 64'(1));

        // Branch from 0 by -2 lands on 0xFFFFFFFF; the sequential successor wraps to 0.
        expect_fetch(32'hFFFF_FFFF);
        step(1'b1, 25'h1FF_FFFE, 1'b0, 0);
        step(1'b0, '0, 1'b0, 100);
        check("wrap_req", 64'(imem_req), 64'(1));
        check("wrap_addr", 64'(imem_addr), 64'(0));

        // Reset mid-fetch with an ack during and right after reset: both must be dropped.
        rst       = 1'b1;
        stale_ack = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        stale_ack = 1'b0;
        ack_delay = 0;
        exp_retired = 0;
        check("midrst_valid", 64'(instr_valid), 64'(0));
        check("midrst_req", 64'(imem_req), 64'(1));
        check("midrst_addr", 64'(imem_addr), 64'(0));
        check("midrst_retired", 64'(retired), 64'(0));
        expect_fetch(32'h0);
        expect_fetch(32'h1);
        step(1'b0, '0, 1'b0, 0);
        step(1'b0, '0, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("addr_q_drained", 64'(addr_q.size()), 64'(0));
        check("cons_q_drained", 64'(cons_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and sequences every fetch of the single-issue RISC core.
- Issues one request at a time to instruction memory using a req/ack handshake, and holds the fetched word for decode.
- Applies taken branches as PC-relative jumps: new PC = instr_pc + 1 + sign-extended offset.
- Also handles decode back-pressure, halt, and a retired-instruction counter.

Parameters:
- PC_WIDTH, 32, width of PC, memory address and retired counter.
- OFFSET_WIDTH, 25, width of the signed branch offset, in instruction words.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_WIDTH  word address of the fetch; equals pc.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc hold a fetched, unconsumed instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  PC_WIDTH  address instr was fetched from.
- stall  in  1  decode cannot accept instr this cycle.
- branch_taken  in  1  the instruction presented on instr is a taken branch.
- branch_offset  in  OFFSET_WIDTH  signed word offset for the branch.
- halt  in  1  the instruction presented on instr is HALT.
- halted  out  1  core stopped; only rst exits this state.
- retired  out  PC_WIDTH  count of instructions consumed by decode.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=S_START, pc=RESET_PC.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, retired=0.
- rst dominates every other input, including while a request is outstanding.
- States:
  - S_START: imem_req=0; imem_ack is ignored, so a stale ack from before reset is discarded. Next state is S_FETCH.
  - S_FETCH: imem_req=1 and imem_addr=pc, both held stable until ack.
    - On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 2^PC_WIDTH), next state S_VALID.
    - Otherwise remain in S_FETCH; there is no timeout.
  - S_VALID: imem_req=0, instr_valid=1; instr and instr_pc are held stable.
    - halt, branch_taken and branch_offset are sampled only here, and only when stall=0.
    - stall=1: hold everything; branch_taken and halt are ignored.
    - stall=0 with halt=1: halted<=1, instr_valid<=0, retired<=retired+1, next state S_HALT. halt has priority over branch_taken.
    - stall=0 with branch_taken=1: pc<=instr_pc+1+sext(branch_offset), instr_valid<=0, retired+1, next state S_FETCH.
    - stall=0 otherwise: instr_valid<=0, retired+1, next state S_FETCH; pc is already instr_pc+1.
  - S_HALT: imem_req=0, instr_valid=0, halted=1; all inputs are ignored. Exit is via rst only.
- Throughput: at best one instruction every 2 cycles (FETCH with same-cycle ack, then VALID).
- Latency: the first imem_req is asserted in the 2nd cycle after rst deasserts.
- Arithmetic:
  - sext replicates branch_offset[OFFSET_WIDTH-1] into the upper bits.
  - All PC sums and retired wrap modulo 2^PC_WIDTH. For example, instr_pc=0xFFFFFFFF with no branch gives next pc=0x00000000.
- imem_ack while not in S_FETCH is ignored.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Test Plan:
- Sequential run: rst for 2 cycles, then ack every request immediately, stall=0 → imem_addr sequence 0,1,2,3; instr_valid pulses every other cycle; retired=4 after the 4th consume.
- Backward and forward branch:
  - At instr_pc=0x10, branch_taken=1, offset=0x1FFFFFC (-4) → next imem_addr=0x0D.
  - At instr_pc=0x10, offset=0x0000005 → next imem_addr=0x16.
- Stall hold: instr_valid=1, stall=1 for 3 cycles with branch_taken=1, then stall=0 with branch_taken=0 → instr and instr_pc unchanged for 3 cycles, no redirect, next address = instr_pc+1, retired increments once.
- Memory wait: ack delayed 5 cycles → imem_req stays 1 and imem_addr stays constant for all 5 cycles; instr captured from the ack-cycle rdata only.
- Halt and reset:
  - halt=1 and branch_taken=1 together with stall=0 → halted=1, no further imem_req for 20 cycles.
  - Then rst=1 → halted=0, pc=RESET_PC, first request 2 cycles after rst falls.
- Reset mid-fetch and wrap: rst asserted while imem_req=1 with an ack arriving in the next cycle → ack ignored, instr_valid=0. Separately, start from pc=0xFFFFFFFF and run with no branch → next fetch is at address 0.
